// File: rtl/disparity_selector.sv
// Winner-take-all: sums path costs, registered argmin tree; latency K+2, 1 pixel/cycle, no backpressure.
// Optional second-best uniqueness test built when DISPARITY_SELECTOR_UNIQUENESS_EN is defined.
module disparity_selector #(
    parameter int DISPARITY_LEVELS = 64,
    parameter int ACC_COST_BITS    = 8,
    parameter int NUM_PATHS        = 4,
    parameter int UNIQ_MARGIN      = 4
) (
    input  logic                                                  in_clk,
    input  logic                                                  in_rst_n,
    input  logic                                                  in_de,
    input  logic                                                  in_line_start,
    input  logic [NUM_PATHS*DISPARITY_LEVELS*ACC_COST_BITS-1:0]   in_L_arr,
    output logic                                                  out_de,
    output logic                                                  out_line_start,
    output logic [$clog2(DISPARITY_LEVELS)-1:0]                   out_disparity,
    output logic [ACC_COST_BITS+$clog2(NUM_PATHS)-1:0]            out_min_cost,
    output logic                                                  out_unique
);

    localparam int K        = $clog2(DISPARITY_LEVELS);
    localparam int SUM_BITS = ACC_COST_BITS + $clog2(NUM_PATHS);
    localparam int DL       = DISPARITY_LEVELS;
    localparam int NODES    = 2 * DL - 1;
    localparam int ROOT     = 2 * DL - 2;

    // Flat node store: leaves at [0, DL), level j at 2*DL - (2*DL >> j).
    // With this layout node i (i >= DL) has children 2*(i-DL) and 2*(i-DL)+1.
    logic [SUM_BITS-1:0] r_min [0:NODES-1];
    logic [K-1:0]        r_idx [0:NODES-1];
    logic [K:0]          r_vld;
    logic [K:0]          r_ls;

    logic [SUM_BITS-1:0] w_sum [0:DL-1];
    logic [SUM_BITS-1:0] w_min [DL:ROOT];
    logic [K-1:0]        w_idx [DL:ROOT];

`ifdef DISPARITY_SELECTOR_UNIQUENESS_EN
    localparam logic [SUM_BITS-1:0] MARGIN = SUM_BITS'(UNIQ_MARGIN);

    logic [SUM_BITS-1:0] r_min2 [0:NODES-1];
    logic [SUM_BITS-1:0] w_min2 [DL:ROOT];

    function automatic logic [SUM_BITS-1:0] f_min(input logic [SUM_BITS-1:0] a,
                                                  input logic [SUM_BITS-1:0] b);
        return (a <= b) ? a : b;
    endfunction
`endif

    always_comb begin
        for (int d = 0; d < DL; d++) begin
            w_sum[d] = '0;
            for (int p = 0; p < NUM_PATHS; p++) begin
                w_sum[d] = w_sum[d] + SUM_BITS'(in_L_arr[ACC_COST_BITS*(p*DL+d) +: ACC_COST_BITS]);
            end
        end
    end

    // Lower-index child wins on equal cost so ties resolve to the lowest disparity.
    always_comb begin
        for (int i = DL; i <= ROOT; i++) begin
            if (r_min[2*(i-DL)] <= r_min[2*(i-DL)+1]) begin
                w_min[i] = r_min[2*(i-DL)];
                w_idx[i] = r_idx[2*(i-DL)];
            end else begin
                w_min[i] = r_min[2*(i-DL)+1];
                w_idx[i] = r_idx[2*(i-DL)+1];
            end
`ifdef DISPARITY_SELECTOR_UNIQUENESS_EN
            w_min2[i] = f_min(f_min(r_min2[2*(i-DL)], r_min2[2*(i-DL)+1]),
                              (r_min[2*(i-DL)] <= r_min[2*(i-DL)+1]) ? r_min[2*(i-DL)+1]
                                                                     : r_min[2*(i-DL)]);
`endif
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_vld <= '0;
            r_ls  <= '0;
            for (int i = 0; i < NODES; i++) begin
                r_min[i] <= '0;
                r_idx[i] <= '0;
`ifdef DISPARITY_SELECTOR_UNIQUENESS_EN
                r_min2[i] <= '0;
`endif
            end
        end else begin
            r_vld[0] <= in_de;
            r_ls[0]  <= in_de & in_line_start;
            for (int j = 1; j <= K; j++) begin
                r_vld[j] <= r_vld[j-1];
                r_ls[j]  <= r_ls[j-1];
            end
            if (in_de) begin
                for (int d = 0; d < DL; d++) begin
                    r_min[d] <= w_sum[d];
                    r_idx[d] <= K'(d);
`ifdef DISPARITY_SELECTOR_UNIQUENESS_EN
                    r_min2[d] <= '1;
`endif
                end
            end
            for (int j = 1; j <= K; j++) begin
                if (r_vld[j-1]) begin
                    for (int n = 2*DL - ((2*DL) >> j); n < 2*DL - (DL >> j); n++) begin
                        r_min[n] <= w_min[n];
                        r_idx[n] <= w_idx[n];
`ifdef DISPARITY_SELECTOR_UNIQUENESS_EN
                        r_min2[n] <= w_min2[n];
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_de         <= 1'b0;
            out_line_start <= 1'b0;
            out_disparity  <= '0;
            out_min_cost   <= '0;
        end else begin
            out_de         <= r_vld[K];
            out_line_start <= r_ls[K];
            if (r_vld[K]) begin
                out_disparity <= r_idx[ROOT];
                out_min_cost  <= r_min[ROOT];
            end
        end
    end

`ifdef DISPARITY_SELECTOR_UNIQUENESS_EN
    // min2 >= min always holds, so the gap subtraction cannot wrap.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_unique <= 1'b1;
        end else if (r_vld[K]) begin
            out_unique <= ((r_min2[ROOT] - r_min[ROOT]) >= MARGIN);
        end
    end
`else
    assign out_unique = 1'b1;
`endif

endmodule
